// File: rtl/mm_arbiter_if.sv
// Handshake bundle between the requesters, the matmul engine and mm_arbiter.
// master = requester/engine side, slave = the arbiter.
interface mm_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int REQ_IDX = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] cmpl;
    logic               eng_start;
    logic               eng_done;
    logic [REQ_IDX-1:0] eng_bank;
    logic               busy;

    modport master (
        output req, eng_done,
        input  gnt, cmpl, eng_start, eng_bank, busy
    );

    modport slave (
        input  req, eng_done,
        output gnt, cmpl, eng_start, eng_bank, busy
    );
endinterface

// File: rtl/mm_arbiter.sv
// Round-robin arbiter granting one matmul engine to NUM_REQ requesters, one job at a time.
// Optional macro MM_ARBITER_STATS_EN adds a saturating 16-bit completed-job counter (job_count).
//
// state   | meaning
// S_IDLE  | no job; sample req, pick round-robin winner
// S_START | winner registered; eng_start pulses on leaving this state
// S_CLR   | wait for the previous job's sticky eng_done to drop
// S_RUN   | wait for eng_done of this job
// S_RESP  | cmpl pulse to winner, gnt already cleared, advance pointer
module mm_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_IDX = 2
) (
    input  logic        clock,
    input  logic        reset,
    mm_arbiter_if.slave bus
`ifdef MM_ARBITER_STATS_EN
    ,
    output logic [15:0] job_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CLR   = 3'd2,
        S_RUN   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t             r_state;
    logic [REQ_IDX-1:0] r_rr_ptr;
    logic [REQ_IDX-1:0] r_eng_bank;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_cmpl;
    logic               r_eng_start;
    logic               r_busy;

    logic               w_any;
    logic [REQ_IDX-1:0] w_win;

    function automatic logic [REQ_IDX-1:0] f_wrap(input int v);
        return REQ_IDX'(v % NUM_REQ);
    endfunction

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[f_wrap(int'(r_rr_ptr) + i)]) begin
                w_any = 1'b1;
                w_win = f_wrap(int'(r_rr_ptr) + i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_eng_bank  <= '0;
            r_gnt       <= '0;
            r_cmpl      <= '0;
            r_eng_start <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            r_cmpl      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state    <= S_START;
                        r_gnt      <= NUM_REQ'(1) << w_win;
                        r_eng_bank <= w_win;
                        r_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    r_eng_start <= 1'b1;
                    r_state     <= S_CLR;
                end
                S_CLR: begin
                    if (!bus.eng_done) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.eng_done) begin
                        r_state <= S_RESP;
                        r_cmpl  <= r_gnt;
                        r_gnt   <= '0;
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= f_wrap(int'(r_eng_bank) + 1);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.cmpl      = r_cmpl;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_bank  = r_eng_bank;
    assign bus.busy      = r_busy;

`ifdef MM_ARBITER_STATS_EN
    logic [15:0] r_job_count;

    // Counts on the same edge that raises cmpl, so the count is visible alongside the pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_job_count <= '0;
        end else if (r_state == S_RUN && bus.eng_done && r_job_count != 16'hFFFF) begin
            r_job_count <= r_job_count + 16'd1;
        end
    end

    assign job_count = r_job_count;
`endif

endmodule
